// File: rtl/artemis_gtp_link_ctrl_pkg.sv
// Shared state codes, sync encoding and helpers for the GTP link controller.
// Optional error counting is enabled with ARTEMIS_GTP_ERR_COUNT_EN.
package artemis_gtp_link_ctrl_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_RESET     = 3'd1;
  localparam logic [2:0] ST_WAIT_PLL  = 3'd2;
  localparam logic [2:0] ST_WAIT_DONE = 3'd3;
  localparam logic [2:0] ST_WAIT_SYNC = 3'd4;
  localparam logic [2:0] ST_LINK_UP   = 3'd5;
  localparam logic [2:0] ST_FAIL      = 3'd6;

  localparam logic [1:0] LOS_IN_SYNC = 2'b00;

  typedef struct packed {
    logic gtp_reset;
    logic link_up;
    logic fail;
  } chan_flags_t;

  // The GTP stays in reset whenever the channel is idle, sequencing reset or failed.
  function automatic chan_flags_t decode_flags(input logic [2:0] st);
    chan_flags_t f;
    f.gtp_reset = (st == ST_IDLE) || (st == ST_RESET) || (st == ST_FAIL);
    f.link_up   = (st == ST_LINK_UP);
    f.fail      = (st == ST_FAIL);
    return f;
  endfunction

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

endpackage

// File: rtl/artemis_gtp_chan_fsm.sv
// One channel's bring-up FSM with timer, sync-stable counter, retry counter
// and, when ARTEMIS_GTP_ERR_COUNT_EN is defined, a saturating error counter.
module artemis_gtp_chan_fsm
  import artemis_gtp_link_ctrl_pkg::*;
#(
  parameter int RESET_CYCLES   = 16,
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int SYNC_STABLE    = 256,
  parameter int MAX_RETRIES    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        pll_detect_k,
  input  logic        dcm_locked,
  input  logic        reset_done,
  input  logic [1:0]  loss_of_sync,
  input  logic        rx_elec_idle,
`ifdef ARTEMIS_GTP_ERR_COUNT_EN
  input  logic [3:0]  disparity_error,
  input  logic [3:0]  rx_not_in_table,
  input  logic        err_clear,
  output logic [15:0] err_count,
`endif
  output logic        gtp_reset,
  output logic        link_up,
  output logic        fail,
  output logic [3:0]  retry_count,
  output logic [2:0]  state
);

  localparam int TMAX = (TIMEOUT_CYCLES > RESET_CYCLES) ? TIMEOUT_CYCLES : RESET_CYCLES;
  localparam int TW   = (TMAX > 2) ? $clog2(TMAX) : 1;
  localparam int SW   = $clog2(SYNC_STABLE + 1);

  localparam logic [TW-1:0] RESET_LAST   = TW'(RESET_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [SW-1:0] SYNC_DONE    = SW'(SYNC_STABLE);
  localparam logic [3:0]    RETRY_LIMIT  = 4'(MAX_RETRIES);

  logic [2:0]    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [SW-1:0] stable_q, stable_d;
  logic [3:0]    retry_q, retry_d;
  chan_flags_t   flags_q, flags_d;
  logic          do_retry, good_sync, link_lost, timed_out;

  assign good_sync = (loss_of_sync == LOS_IN_SYNC) && !rx_elec_idle;
  assign link_lost = !pll_detect_k || !dcm_locked || loss_of_sync[1];
  assign timed_out = (timer_q == TIMEOUT_LAST);

  // Timer and stable counter default to zero so every state change clears them.
  always_comb begin
    state_d  = state_q;
    timer_d  = '0;
    stable_d = '0;
    retry_d  = retry_q;
    do_retry = 1'b0;
    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_RESET;
        ST_RESET: begin
          if (timer_q == RESET_LAST) state_d = ST_WAIT_PLL;
          else timer_d = timer_q + 1'b1;
        end
        ST_WAIT_PLL: begin
          if (timed_out) do_retry = 1'b1;
          else if (pll_detect_k && dcm_locked) state_d = ST_WAIT_DONE;
          else timer_d = timer_q + 1'b1;
        end
        ST_WAIT_DONE: begin
          if (timed_out) do_retry = 1'b1;
          else if (reset_done) state_d = ST_WAIT_SYNC;
          else timer_d = timer_q + 1'b1;
        end
        ST_WAIT_SYNC: begin
          if (timed_out) begin
            do_retry = 1'b1;
          end else begin
            stable_d = good_sync ? stable_q + 1'b1 : '0;
            if (stable_d == SYNC_DONE) begin
              state_d  = ST_LINK_UP;
              stable_d = '0;
            end else begin
              timer_d = timer_q + 1'b1;
            end
          end
        end
        ST_LINK_UP: if (link_lost) do_retry = 1'b1;
        ST_FAIL: state_d = ST_FAIL;
        default: state_d = ST_IDLE;
      endcase
    end
    if (do_retry) begin
      retry_d = (retry_q == 4'hF) ? retry_q : retry_q + 1'b1;
      state_d = (retry_d == RETRY_LIMIT) ? ST_FAIL : ST_RESET;
    end
    if (state_d == ST_IDLE) retry_d = '0;
    flags_d = decode_flags(state_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      timer_q  <= '0;
      stable_q <= '0;
      retry_q  <= '0;
      flags_q  <= decode_flags(ST_IDLE);
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      stable_q <= stable_d;
      retry_q  <= retry_d;
      flags_q  <= flags_d;
    end
  end

  assign gtp_reset   = flags_q.gtp_reset;
  assign link_up     = flags_q.link_up;
  assign fail        = flags_q.fail;
  assign retry_count = retry_q;
  assign state       = state_q;

`ifdef ARTEMIS_GTP_ERR_COUNT_EN
  logic [15:0] err_q, err_d;
  logic [16:0] err_sum;

  // A global clear beats both the RESET-entry clear and a same-cycle increment.
  always_comb begin
    err_sum = {1'b0, err_q} + 17'(popcount4(disparity_error | rx_not_in_table));
    err_d   = err_q;
    if (state_q == ST_LINK_UP) err_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];
    if ((state_d == ST_RESET) && (state_q != ST_RESET)) err_d = '0;
    if (err_clear) err_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) err_q <= '0;
    else     err_q <= err_d;
  end

  assign err_count = err_q;
`endif

endmodule

// File: rtl/artemis_gtp_link_ctrl.sv
// Top level: slices the per-channel buses onto NUM_CHANNELS independent FSMs.
// Optional error-count ports appear when ARTEMIS_GTP_ERR_COUNT_EN is defined.
module artemis_gtp_link_ctrl
  import artemis_gtp_link_ctrl_pkg::*;
#(
  parameter int NUM_CHANNELS   = 2,
  parameter int RESET_CYCLES   = 16,
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int SYNC_STABLE    = 256,
  parameter int MAX_RETRIES    = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_CHANNELS-1:0]     i_enable,
  input  logic [NUM_CHANNELS-1:0]     i_pll_detect_k,
  input  logic [NUM_CHANNELS-1:0]     i_dcm_locked,
  input  logic [NUM_CHANNELS-1:0]     i_reset_done,
  input  logic [2*NUM_CHANNELS-1:0]   i_loss_of_sync,
  input  logic [NUM_CHANNELS-1:0]     i_rx_elec_idle,
`ifdef ARTEMIS_GTP_ERR_COUNT_EN
  input  logic [4*NUM_CHANNELS-1:0]   i_disparity_error,
  input  logic [4*NUM_CHANNELS-1:0]   i_rx_not_in_table,
  input  logic                        i_err_clear,
  output logic [16*NUM_CHANNELS-1:0]  o_err_count,
`endif
  output logic [NUM_CHANNELS-1:0]     o_gtp_reset,
  output logic [NUM_CHANNELS-1:0]     o_link_up,
  output logic [NUM_CHANNELS-1:0]     o_fail,
  output logic [4*NUM_CHANNELS-1:0]   o_retry_count,
  output logic [3*NUM_CHANNELS-1:0]   o_state
);

  for (genvar k = 0; k < NUM_CHANNELS; k++) begin : g_chan
    artemis_gtp_chan_fsm #(
      .RESET_CYCLES  (RESET_CYCLES),
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
      .SYNC_STABLE   (SYNC_STABLE),
      .MAX_RETRIES   (MAX_RETRIES)
    ) u_fsm (
      .clk            (clk),
      .rst            (rst),
      .enable         (i_enable[k]),
      .pll_detect_k   (i_pll_detect_k[k]),
      .dcm_locked     (i_dcm_locked[k]),
      .reset_done     (i_reset_done[k]),
      .loss_of_sync   (i_loss_of_sync[2*k +: 2]),
      .rx_elec_idle   (i_rx_elec_idle[k]),
`ifdef ARTEMIS_GTP_ERR_COUNT_EN
      .disparity_error(i_disparity_error[4*k +: 4]),
      .rx_not_in_table(i_rx_not_in_table[4*k +: 4]),
      .err_clear      (i_err_clear),
      .err_count      (o_err_count[16*k +: 16]),
`endif
      .gtp_reset      (o_gtp_reset[k]),
      .link_up        (o_link_up[k]),
      .fail           (o_fail[k]),
      .retry_count    (o_retry_count[4*k +: 4]),
      .state          (o_state[3*k +: 3])
    );
  end

endmodule

// File: tb/tb_artemis_gtp_link_ctrl.sv
// Self-checking bench: directed bring-up scenarios plus randomized traffic
// compared every cycle against a phase/age behavioural model.
module tb_artemis_gtp_link_ctrl;

  localparam int N     = 2;
  localparam int RST_C = 4;
  localparam int TMO   = 32;
  localparam int SYNC  = 8;
  localparam int MAXR  = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   en, pll, dcm, done, eidle;
  logic [2*N-1:0] los;
  logic [N-1:0]   o_gtp_reset, o_link_up, o_fail;
  logic [4*N-1:0] o_retry_count;
  logic [3*N-1:0] o_state;
`ifdef ARTEMIS_GTP_ERR_COUNT_EN
  logic [4*N-1:0]  de, nit;
  logic            err_clear;
  logic [16*N-1:0] o_err_count;
`endif

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;

  int m_phase[N], m_age[N], m_good[N], m_retries[N], m_err[N];

  always #5 clk = ~clk;

  artemis_gtp_link_ctrl #(
    .NUM_CHANNELS(N), .RESET_CYCLES(RST_C), .TIMEOUT_CYCLES(TMO),
    .SYNC_STABLE(SYNC), .MAX_RETRIES(MAXR)
  ) dut (
    .clk(clk), .rst(rst), .i_enable(en), .i_pll_detect_k(pll), .i_dcm_locked(dcm),
    .i_reset_done(done), .i_loss_of_sync(los), .i_rx_elec_idle(eidle),
`ifdef ARTEMIS_GTP_ERR_COUNT_EN
    .i_disparity_error(de), .i_rx_not_in_table(nit), .i_err_clear(err_clear),
    .o_err_count(o_err_count),
`endif
    .o_gtp_reset(o_gtp_reset), .o_link_up(o_link_up), .o_fail(o_fail),
    .o_retry_count(o_retry_count), .o_state(o_state)
  );

  task automatic compare(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fails++;
      $display("[TB] FAIL %s cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Phases use the state codes 0..6; age = cycles already spent in the phase.
  task automatic modelStep();
    for (int ch = 0; ch < N; ch++) begin
      int  nxt;
      int  run;
      bit  rtry;
      bit  good;
      bit  lost;
      if (rst) begin
        m_phase[ch] = 0; m_age[ch] = 0; m_good[ch] = 0; m_retries[ch] = 0; m_err[ch] = 0;
        continue;
      end
      good = (los[2*ch +: 2] == 2'b00) && !eidle[ch];
      lost = !pll[ch] || !dcm[ch] || los[2*ch+1];
      nxt  = m_phase[ch];
      run  = 0;
      rtry = 0;
      if (!en[ch]) nxt = 0;
      else if (m_phase[ch] == 0) nxt = 1;
      else if (m_phase[ch] == 1) begin
        if (m_age[ch] + 1 >= RST_C) nxt = 2;
      end else if (m_phase[ch] >= 2 && m_phase[ch] <= 4) begin
        if (m_age[ch] + 1 >= TMO) rtry = 1;
        else if (m_phase[ch] == 2) begin
          if (pll[ch] && dcm[ch]) nxt = 3;
        end else if (m_phase[ch] == 3) begin
          if (done[ch]) nxt = 4;
        end else begin
          run = good ? m_good[ch] + 1 : 0;
          if (run >= SYNC) nxt = 5;
        end
      end else if (m_phase[ch] == 5) begin
        if (lost) rtry = 1;
      end
      if (rtry) begin
        if (m_retries[ch] < 15) m_retries[ch]++;
        nxt = (m_retries[ch] == MAXR) ? 6 : 1;
      end
`ifdef ARTEMIS_GTP_ERR_COUNT_EN
      if (err_clear) m_err[ch] = 0;
      else if (nxt == 1 && m_phase[ch] != 1) m_err[ch] = 0;
      else if (m_phase[ch] == 5) begin
        m_err[ch] += $countones(de[4*ch +: 4] | nit[4*ch +: 4]);
        if (m_err[ch] > 65535) m_err[ch] = 65535;
      end
`endif
      m_good[ch]  = (nxt == 4 && m_phase[ch] == 4) ? run : 0;
      m_age[ch]   = (nxt == m_phase[ch] && !rtry) ? m_age[ch] + 1 : 0;
      if (nxt == 0) m_retries[ch] = 0;
      m_phase[ch] = nxt;
    end
  endtask

  task automatic checkOutput();
    for (int ch = 0; ch < N; ch++) begin
      int p;
      p = m_phase[ch];
      compare($sformatf("state ch%0d", ch), int'(o_state[3*ch +: 3]), p);
      compare($sformatf("gtp_reset ch%0d", ch), int'(o_gtp_reset[ch]),
              (p == 0 || p == 1 || p == 6) ? 1 : 0);
      compare($sformatf("link_up ch%0d", ch), int'(o_link_up[ch]), (p == 5) ? 1 : 0);
      compare($sformatf("fail ch%0d", ch), int'(o_fail[ch]), (p == 6) ? 1 : 0);
      compare($sformatf("retry ch%0d", ch), int'(o_retry_count[4*ch +: 4]), m_retries[ch]);
`ifdef ARTEMIS_GTP_ERR_COUNT_EN
      compare($sformatf("err_count ch%0d", ch), int'(o_err_count[16*ch +: 16]), m_err[ch]);
`endif
    end
  endtask

  task automatic tick();
    modelStep();
    @(negedge clk);
    checkOutput();
    cyc++;
  endtask

  // Noisy segments drop lock/sync occasionally; quiet ones let links come up.
  task automatic applyStimulus(input bit noisy);
    rst = ($urandom_range(0, 799) == 0);
    for (int ch = 0; ch < N; ch++) begin
      if ($urandom_range(0, 99) == 0) en[ch] = ~en[ch];
      pll[ch]   = noisy ? ($urandom_range(0, 39) != 0) : 1'b1;
      dcm[ch]   = noisy ? ($urandom_range(0, 39) != 0) : 1'b1;
      done[ch]  = noisy ? ($urandom_range(0, 9) != 0) : 1'b1;
      eidle[ch] = noisy ? ($urandom_range(0, 19) == 0) : 1'b0;
      los[2*ch +: 2] = (noisy && $urandom_range(0, 15) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
`ifdef ARTEMIS_GTP_ERR_COUNT_EN
      de[4*ch +: 4]  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      nit[4*ch +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
`endif
    end
`ifdef ARTEMIS_GTP_ERR_COUNT_EN
    err_clear = ($urandom_range(0, 299) == 0);
`endif
  endtask

  initial begin
    bit noisy;
    rst = 1'b1; en = '0; pll = '0; dcm = '0; done = '0; los = '0; eidle = '0;
`ifdef ARTEMIS_GTP_ERR_COUNT_EN
    de = '0; nit = '0; err_clear = 1'b0;
`endif
    for (int i = 0; i < N; i++) begin
      m_phase[i] = 0; m_age[i] = 0; m_good[i] = 0; m_retries[i] = 0; m_err[i] = 0;
    end
    repeat (3) tick();
    compare("reset gtp_reset", int'(o_gtp_reset), 3);
    compare("reset state", int'(o_state), 0);
    compare("reset link_up", int'(o_link_up), 0);

    $display("[TB] nominal bring-up");
    rst = 1'b0; en = 2'b11;
    for (int i = 0; i <= 35; i++) begin
      pll  = (i >= 10) ? 2'b11 : 2'b00;
      dcm  = pll;
      done = (i >= 20) ? 2'b11 : 2'b00;
      tick();
      if (i == 3)  compare("lit reset state", int'(o_state[2:0]), 1);
      if (i == 4)  compare("lit wait_pll gtp_reset", int'(o_gtp_reset[0]), 0);
      if (i == 27) compare("lit link not yet", int'(o_link_up), 0);
      if (i == 28) compare("lit link up", int'(o_link_up), 3);
    end
    compare("lit retry after bring-up", int'(o_retry_count), 0);

    $display("[TB] link drop on dcm");
    dcm = 2'b10;
    tick();
    compare("lit drop link0", int'(o_link_up), 2);
    compare("lit drop state0", int'(o_state[2:0]), 1);
    compare("lit drop retry0", int'(o_retry_count[3:0]), 1);
    dcm = 2'b11;
    repeat (20) tick();
    compare("lit relink", int'(o_link_up), 3);

    $display("[TB] sync glitch");
    en = 2'b10;
    tick();
    compare("lit idle retry0", int'(o_retry_count[3:0]), 0);
    en = 2'b11;
    for (int j = 0; j <= 24; j++) begin
      los[1:0] = (j == 12) ? 2'b10 : 2'b00;
      tick();
      if (j == 19) compare("lit glitch link0 low", int'(o_link_up[0]), 0);
      if (j == 20) compare("lit glitch link0 high", int'(o_link_up[0]), 1);
    end

    $display("[TB] timeout to fail");
    pll = 2'b10; en = 2'b10;
    tick();
    en = 2'b11;
    repeat (115) tick();
    compare("lit fail0", int'(o_fail[0]), 1);
    compare("lit fail retry0", int'(o_retry_count[3:0]), 3);
    compare("lit ch1 still up", int'(o_link_up[1]), 1);
    en = 2'b10;
    tick();
    compare("lit fail cleared state0", int'(o_state[2:0]), 0);

    $display("[TB] abort and reset");
    pll = 2'b11; done = 2'b10; en = 2'b11;
    repeat (8) tick();
    compare("lit wait_done", int'(o_state[2:0]), 3);
    en = 2'b10;
    tick();
    compare("lit abort idle", int'(o_state[2:0]), 0);
    en = 2'b11;
    tick();
    compare("lit restart reset", int'(o_state[2:0]), 1);
    done = 2'b11;
    repeat (20) tick();
    rst = 1'b1;
    tick();
    compare("lit rst state", int'(o_state), 0);
    compare("lit rst gtp_reset", int'(o_gtp_reset), 3);
    compare("lit rst link_up", int'(o_link_up), 0);
    rst = 1'b0;
    repeat (20) tick();

`ifdef ARTEMIS_GTP_ERR_COUNT_EN
    $display("[TB] error counter");
    de = 8'h03;
    repeat (3) tick();
    de = 8'h00;
    tick();
    compare("lit err six", int'(o_err_count[15:0]), 6);
    de = 8'h03; err_clear = 1'b1;
    tick();
    compare("lit err clear wins", int'(o_err_count[15:0]), 0);
    err_clear = 1'b0; de = 8'hFF;
    repeat (16400) tick();
    compare("lit err saturate", int'(o_err_count[15:0]), 65535);
    de = 8'h00;
`endif

    $display("[TB] randomized traffic");
    noisy = 1'b0;
    for (int k = 0; k < 4000; k++) begin
      if (k % 100 == 0) noisy = ($urandom_range(0, 1) == 1);
      applyStimulus(noisy);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
